// File: rtl/alu_mdu_controller.sv
// alu_mdu_controller
//   Decodes single-cycle ALU operations into a 3-bit ALU control word. It also
//   runs a multi-cycle multiply/divide unit (MDU) that writes the HI/LO result
//   registers.
//
//   MDU sequence (cycle 0 is the IDLE cycle that accepts the op):
//     IDLE (0) -> RUN (1..WIDTH) -> FIX (WIDTH+1) -> DONE (WIDTH+2) -> IDLE
//
//   Handshake: start qualifies alu_op/a/b. While stall is high, the issuer
//   must hold the instruction. An MDU op is taken at the edge that closes the
//   IDLE cycle in which start=1 and alu_op is a valid MDU code. done pulses
//   for one cycle when hi/lo hold the new result.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   alu_op[4:0]     bit4=0 ALU op, bit4=1 MDU op (10000..10011 valid)
//   start           instruction valid
//   a, b            operands (multiplicand/dividend, multiplier/divisor)
//   wr_hi, wr_lo    direct HI/LO write strobes, honoured only in IDLE
//   wdata           data for the direct writes
//   alu_ctr[2:0]    combinational ALU control
//   stall           combinational hold request
//   done            registered one-cycle MDU completion pulse
//   hi, lo          registered result registers
//   dbg_state[1:0]  current FSM state (0 IDLE, 1 RUN, 2 FIX, 3 DONE)
module alu_mdu_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       alu_op,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [2:0]       alu_ctr,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            op_div;   // 1: divide, 0: multiply
  logic            neg_q;    // negate product (mult) or quotient (div)
  logic            neg_r;    // negate remainder (div only)
  logic [WIDTH-1:0] acc;     // product high half / partial remainder
  logic [WIDTH-1:0] wrk;     // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] opm;     // multiplicand / divisor magnitude

  logic mdu_valid, accept;
  assign mdu_valid = alu_op[4] && (alu_op[3:2] == 2'b00);
  assign accept    = (state == S_IDLE) && start && mdu_valid;
  assign dbg_state = state;

  // ALU control decode
  always_comb begin
    alu_ctr = 3'd0;
    if (!alu_op[4]) begin
      case (alu_op[3:0])
        4'd0, 4'd1, 4'd14, 4'd15: alu_ctr = 3'd7;
        4'd4:                     alu_ctr = 3'd4;
        4'd5, 4'd7:               alu_ctr = 3'd5;
        4'd6:                     alu_ctr = 3'd2;
        4'd8:                     alu_ctr = 3'd3;
        4'd9:                     alu_ctr = 3'd1;
        4'd10, 4'd11:             alu_ctr = 3'd6;
        default:                  alu_ctr = 3'd0;
      endcase
    end
  end

  assign stall = accept || (state == S_RUN) || (state == S_FIX);

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_RUN;
      S_RUN:  if (cnt == CNT_ONE) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture: signed ops become magnitudes plus sign flags.
  logic             is_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign is_signed = ~alu_op[0];
  assign sa    = is_signed & a[WIDTH-1];
  assign sb    = is_signed & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // One iteration of shift-add multiply / restoring shift-subtract divide.
  logic [WIDTH:0] mul_sum, rem_sh, diff;
  assign mul_sum = {1'b0, acc} + (wrk[0] ? {1'b0, opm} : '0);
  assign rem_sh  = {acc, wrk[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, opm};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc, wrk};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -wrk : wrk;
  assign rem_fix  = neg_r ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      wrk    <= '0;
      opm    <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == S_FIX);
      if (accept) begin
        cnt    <= CNT_LOAD;
        op_div <= alu_op[1];
        acc    <= '0;
        neg_r  <= sa;
        if (alu_op[1]) begin
          wrk   <= mag_a;
          opm   <= mag_b;
          // Divide by zero keeps an all-ones quotient unsigned.
          neg_q <= (sa ^ sb) && (b != '0);
        end else begin
          wrk   <= mag_b;
          opm   <= mag_a;
          neg_q <= sa ^ sb;
        end
      end else if (state == S_RUN) begin
        cnt <= cnt - CNT_ONE;
        if (op_div) begin
          if (!diff[WIDTH]) begin
            acc <= diff[WIDTH-1:0];
            wrk <= {wrk[WIDTH-2:0], 1'b1};
          end else begin
            acc <= rem_sh[WIDTH-1:0];
            wrk <= {wrk[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc <= mul_sum[WIDTH:1];
          wrk <= {mul_sum[0], wrk[WIDTH-1:1]};
        end
      end
    end
  end

  // HI/LO: direct writes in IDLE, MDU result at the closing edge of FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      if (op_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end else if (state == S_IDLE) begin
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Testbench for alu_mdu_controller (WIDTH=32): directed and random MDU ops
// checked against an arithmetic reference model, plus ALU decode, direct
// HI/LO writes and reset-abort behaviour.
module tb_alu_mdu_controller;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [4:0]   alu_op;
  logic         start;
  logic [W-1:0] a, b;
  logic         wr_hi, wr_lo;
  logic [W-1:0] wdata;
  logic [2:0]   alu_ctr;
  logic         stall, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  alu_mdu_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .start(start), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .alu_ctr(alu_ctr),
    .stall(stall), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference model: {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] model(input logic [4:0] op,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op[1:0])
      2'd0: return 64'(sx * sy);
      2'd1: return 64'(ux * uy);
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one MDU op at the next negedge (cycle 0) and follows it to DONE.
  // inj_wr: pulse wr_hi during RUN; co_wr: wr_lo together with start.
  task automatic run_mdu(input logic [4:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit inj_wr, input bit co_wr);
    logic [2*W-1:0] e;
    logic [W-1:0] hi_before;
    exp_q.push_back(model(op, x, y));
    @(negedge clk);
    hi_before = hi;
    start = 1'b1; alu_op = op; a = x; b = y;
    if (co_wr) begin wr_lo = 1'b1; wdata = 32'h0000_0055; end
    #1 chk("stall_c0", 64'(stall), 64'd1);
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      start = 1'b0; wr_lo = 1'b0;
      a = $urandom; b = $urandom; alu_op = 5'($urandom);
      if (inj_wr && c == 5) begin wr_hi = 1'b1; wdata = 32'h0000_1234; end
      if (c == 6) wr_hi = 1'b0;
      #1;
      if (c == 1 && co_wr) chk("co_wr_lo", 64'(lo), 64'h55);
      if (inj_wr && c == 7) chk("run_wr_hi_ignored", 64'(hi), 64'(hi_before));
      if (c <= W + 1) begin
        chk("stall_run", 64'(stall), 64'd1);
        chk("done_early", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_pulse", 64'(done), 64'd1);
        chk("stall_done", 64'(stall), 64'd0);
        chk("hi", 64'(hi), 64'(e[2*W-1:W]));
        chk("lo", 64'(lo), 64'(e[W-1:0]));
      end
    end
    @(negedge clk);
    #1 chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic write_hilo(input bit wh, input bit wl, input logic [W-1:0] d);
    @(negedge clk);
    wr_hi = wh; wr_lo = wl; wdata = d;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  // ---------------- directed / random sequence ----------------
  logic [2:0] ctr_tab [16] = '{3'd7,3'd7,3'd0,3'd0,3'd4,3'd5,3'd2,3'd5,
                               3'd3,3'd1,3'd6,3'd6,3'd0,3'd0,3'd7,3'd7};
  logic [W-1:0] edge_v [4] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000};

  initial begin
    logic [4:0] rop;
    logic [W-1:0] rx, ry;
    bit saw_done;
    rst = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    // Known HI/LO, then ALU decode sweep must leave them untouched.
    write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("wr_both_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("wr_both_lo", 64'(lo), 64'hA5A5_A5A5);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = 1'b1; alu_op = 5'(i); a = $urandom; b = $urandom;
      #1;
      chk($sformatf("alu_ctr_%0d", i), 64'(alu_ctr), 64'(ctr_tab[i]));
      chk("alu_stall", 64'(stall), 64'd0);
    end
    // Reserved MDU codes: no stall, alu_ctr 0, no sequence.
    for (int i = 20; i < 32; i++) begin
      @(negedge clk);
      start = 1'b1; alu_op = 5'(i);
      #1;
      chk("rsv_stall", 64'(stall), 64'd0);
      chk("rsv_ctr", 64'(alu_ctr), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("alu_hi_kept", 64'(hi), 64'hA5A5_A5A5);
    chk("alu_lo_kept", 64'(lo), 64'hA5A5_A5A5);
    chk("alu_state_idle", 64'(dbg_state), 64'd0);

    // Directed MDU cases
    run_mdu(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
    run_mdu(5'b10000, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_mdu(5'b10010, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    run_mdu(5'b10010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_mdu(5'b10011, 32'd5, 32'd0, 1'b0, 1'b0);
    run_mdu(5'b10010, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);

    // Direct LO write in IDLE
    write_hilo(1'b0, 1'b1, 32'h0000_0055);
    #1 chk("idle_wr_lo", 64'(lo), 64'h55);

    // Reset at cycle 10 of a MULTU aborts it.
    @(negedge clk);
    start = 1'b1; alu_op = 5'b10001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    #1;
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    run_mdu(5'b10011, 32'd100, 32'd7, 1'b0, 1'b0);

    // Random MDU ops
    for (int i = 0; i < 16; i++) begin
      rop = 5'(16 + $urandom_range(0, 3));
      rx  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      ry  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 15));
      run_mdu(rop, rx, ry, 1'($urandom_range(0, 1)), 1'b0);
    end

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
